// File: rtl/alt_vipitc130_is2vid_read_buffer.sv
// Read buffer between a show-ahead FIFO and the video output stage.
// It holds one FIFO word. In SD mode it emits the word as one colour-plane
// sample per ena cycle. In HD mode it passes the whole word through in one
// ena cycle. Ancillary words (convert=0) emit plane 0 only.
//
// Handshake: the FIFO side is show-ahead. valid_in means data_in/packet_in
// already hold the head word. rdreq_out is a combinational acknowledge: a
// word is taken in exactly the cycles where valid_in & rdreq_out are both 1.
// The video side has no back-pressure. A sample is consumed on every cycle
// with ena=1 while valid_out=1. ena while valid_out=0 is an underflow and is
// ignored.
module alt_vipitc130_is2vid_read_buffer #(
   parameter int DATA_WIDTH              = 20,
   parameter int NUMBER_OF_COLOUR_PLANES = 2,
   parameter int BPS                     = 10
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  convert,
   input  logic                  hd_sdn,
   input  logic                  flush,
   input  logic                  valid_in,
   input  logic [DATA_WIDTH-1:0] data_in,
   input  logic                  packet_in,
   output logic                  rdreq_out,
   input  logic                  ena,
   output logic                  valid_out,
   output logic [DATA_WIDTH-1:0] data_out,
   output logic                  packet_out
);

   localparam int CNT_W = (NUMBER_OF_COLOUR_PLANES > 1) ? $clog2(NUMBER_OF_COLOUR_PLANES) : 1;
   localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(NUMBER_OF_COLOUR_PLANES - 1);

   logic [DATA_WIDTH-1:0] buf_q, buf_d;
   logic                  buf_valid_q, buf_valid_d;
   logic                  buf_packet_q, buf_packet_d;
   logic                  hd_q, hd_d;
   logic                  conv_q, conv_d;
   logic [CNT_W-1:0]      cnt_q, cnt_d;

   logic                  last;
   logic                  consume;
   logic                  load;
   logic [BPS-1:0]        sample;

   // The current sample is the final one of the buffered word in three cases:
   // HD (whole word), ancillary (plane 0 only), or the last colour plane.
   assign last    = hd_q | ~conv_q | (cnt_q == LAST_CNT);
   assign consume = ena & buf_valid_q;
   // Take a new word when the buffer is empty or is draining its final
   // sample this cycle, so words flow back-to-back without a bubble.
   assign load    = valid_in & ~flush & (~buf_valid_q | (consume & last));
   assign rdreq_out = load;

   // Next-state logic. Flush wins over load and consume. The word buffer and
   // the latched mode are kept when the buffer empties. They are only read
   // again after a fresh load.
   always_comb begin
      buf_d        = buf_q;
      buf_valid_d  = buf_valid_q;
      buf_packet_d = buf_packet_q;
      hd_d         = hd_q;
      conv_d       = conv_q;
      cnt_d        = cnt_q;
      if (flush) begin
         buf_valid_d  = 1'b0;
         buf_packet_d = 1'b0;
         cnt_d        = '0;
      end else if (load) begin
         buf_d        = data_in;
         buf_valid_d  = 1'b1;
         buf_packet_d = packet_in;
         hd_d         = hd_sdn;
         conv_d       = convert;
         cnt_d        = '0;
      end else if (consume) begin
         if (last) begin
            buf_valid_d  = 1'b0;
            buf_packet_d = 1'b0;
            cnt_d        = '0;
         end else begin
            cnt_d = cnt_q + CNT_W'(1);
         end
      end
   end

   // State registers with asynchronous active-low clear.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         buf_q        <= '0;
         buf_valid_q  <= 1'b0;
         buf_packet_q <= 1'b0;
         hd_q         <= 1'b0;
         conv_q       <= 1'b0;
         cnt_q        <= '0;
      end else begin
         buf_q        <= buf_d;
         buf_valid_q  <= buf_valid_d;
         buf_packet_q <= buf_packet_d;
         hd_q         <= hd_d;
         conv_q       <= conv_d;
         cnt_q        <= cnt_d;
      end
   end

   // Select the active colour plane. Ancillary words always use plane 0.
   always_comb begin
      sample = buf_q[BPS-1:0];
      for (int p = 0; p < NUMBER_OF_COLOUR_PLANES; p++) begin
         if (conv_q && (cnt_q == CNT_W'(p))) begin
            sample = buf_q[p*BPS +: BPS];
         end
      end
   end

   // HD outputs the full word. SD outputs one zero-extended plane sample.
   always_comb begin
      data_out = '0;
      if (hd_q) begin
         data_out = buf_q;
      end else begin
         data_out[BPS-1:0] = sample;
      end
   end

   assign valid_out  = buf_valid_q;
   assign packet_out = buf_packet_q & buf_valid_q;

endmodule
